// File: rtl/step_exec_pkg.sv
// Shared definitions for the single-step sequencer: opcodes, FSM states and
// instruction field positions.
package step_exec_pkg;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 6;
  localparam int DST_HI = 5;
  localparam int DST_LO = 4;
  localparam int SRC_HI = 3;
  localparam int SRC_LO = 2;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;
  localparam int SH_HI  = 1;
  localparam int SH_LO  = 0;

  typedef enum logic [1:0] {
    OP_LDI = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_SHL = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_WRITE = 2'b11
  } state_t;

endpackage

// File: rtl/step_regfile.sv
// Four-entry register file: two combinational read ports, one synchronous
// write port, asynchronous clear.
module step_regfile #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       raddr_a,
  input  logic [1:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] regs [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/step_exec_ctrl.sv
// Single-step sequencer: each step rising edge latches sw as an instruction and
// walks it through fetch, execute and write-back on a 4-entry register file.
module step_exec_ctrl
  import step_exec_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] result,
  output logic             flag,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count,
  output state_t           state
);

  state_t             state_next;
  logic               step_q;
  logic               start;
  logic [WIDTH-1:0]   ir;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_flag;
  logic [WIDTH-1:0]   rd_a;
  logic [WIDTH-1:0]   rd_b;
  logic [WIDTH-1:0]   alu_val;
  logic               alu_c;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shl_full;

  opcode_t    op;
  logic [1:0] dst;
  logic [1:0] src;
  logic [1:0] sh;
  logic [3:0] imm;

  assign op  = opcode_t'(ir[OPC_HI:OPC_LO]);
  assign dst = ir[DST_HI:DST_LO];
  assign src = ir[SRC_HI:SRC_LO];
  assign sh  = ir[SH_HI:SH_LO];
  assign imm = ir[IMM_HI:IMM_LO];

  // step_q resets high so a press held across reset release is not an edge.
  assign start = step & ~step_q & (state == S_IDLE);

  step_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (state == S_WRITE),
    .waddr   (dst),
    .wdata   (alu_res),
    .raddr_a (dst),
    .raddr_b (src),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: state_next = S_EXEC;
      S_EXEC:  state_next = S_WRITE;
      S_WRITE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    alu_val  = '0;
    alu_c    = 1'b0;
    sum      = {1'b0, a} + {1'b0, b};
    shl_full = {{WIDTH{1'b0}}, a} << sh;
    case (op)
      OP_LDI: alu_val = {{(WIDTH-4){1'b0}}, imm};
      OP_ADD: begin
        alu_val = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OP_SUB: begin
        alu_val = a - b;
        alu_c   = (a < b);
      end
      OP_SHL: begin
        alu_val = shl_full[WIDTH-1:0];
        alu_c   = |shl_full[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q      <= 1'b1;
      busy        <= 1'b0;
      ir          <= '0;
      a           <= '0;
      b           <= '0;
      alu_res     <= '0;
      alu_flag    <= 1'b0;
      result      <= '0;
      flag        <= 1'b0;
      instr_count <= '0;
    end else begin
      step_q <= step;
      busy   <= (state_next != S_IDLE);
      case (state)
        S_IDLE:  if (start) ir <= sw;
        S_FETCH: begin
          a <= rd_a;
          b <= rd_b;
        end
        S_EXEC: begin
          alu_res  <= alu_val;
          alu_flag <= alu_c;
        end
        S_WRITE: begin
          result      <= alu_res;
          flag        <= alu_flag;
          instr_count <= instr_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_step_exec_ctrl.sv
// Bench for step_exec_ctrl: behavioural instruction-level model checked every
// cycle, directed scenarios with literal expectations, then random stepping.
module tb_step_exec_ctrl;
  import step_exec_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step = 1'b1;
  logic [7:0] sw = 8'h00;
  logic [7:0] result;
  logic       flag;
  logic       busy;
  logic [7:0] instr_count;
  state_t     state;

  int checks = 0;
  int fails  = 0;

  step_exec_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .step        (step),
    .sw          (sw),
    .result      (result),
    .flag        (flag),
    .busy        (busy),
    .instr_count (instr_count),
    .state       (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_regs [4];
  int m_result, m_flag, m_count, m_left, m_prev;
  int m_instr;

  task automatic model_execute(input int ins);
    int op, d, s, av, bv, r, f;
    op = (ins >> 6) & 3;
    d  = (ins >> 4) & 3;
    s  = (ins >> 2) & 3;
    av = m_regs[d];
    bv = m_regs[s];
    r = 0;
    f = 0;
    case (op)
      0: r = ins & 15;
      1: begin r = (av + bv) % 256; f = (av + bv) > 255 ? 1 : 0; end
      2: begin r = (av - bv + 256) % 256; f = (av < bv) ? 1 : 0; end
      default: begin
        r = (av * (1 << (ins & 3)));
        f = (r >= 256) ? 1 : 0;
        r = r % 256;
      end
    endcase
    m_regs[d] = r;
    m_result  = r;
    m_flag    = f;
    m_count   = (m_count + 1) % 256;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 0;
      m_result = 0; m_flag = 0; m_count = 0; m_left = 0; m_prev = 1; m_instr = 0;
    end else begin
      if (m_left == 0) begin
        if (step && m_prev == 0) begin
          m_instr = int'(sw);
          m_left  = 3;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) model_execute(m_instr);
      end
      m_prev = step ? 1 : 0;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("model_result", int'(result), m_result);
      check("model_flag", int'(flag), m_flag);
      check("model_busy", int'(busy), (m_left != 0) ? 1 : 0);
      check("model_count", int'(instr_count), m_count);
    end
  end

  // ---------------- driver tasks ----------------
  int busy_cycles;

  task automatic run_instr(input logic [7:0] v);
    @(negedge clk);
    sw   = v;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 10) begin
      busy_cycles++;
      @(negedge clk);
    end
    if (busy_cycles >= 10) check("busy_timeout", busy_cycles, 3);
  endtask

  task automatic run_check(input string name, input logic [7:0] v,
                           input int exp_r, input int exp_f);
    run_instr(v);
    check({name, "_result"}, int'(result), exp_r);
    check({name, "_flag"}, int'(flag), exp_f);
  endtask

  logic [7:0] add_exp [5];
  logic [4:0] add_flag_exp;

  initial begin
    add_exp[0] = 8'h1E; add_exp[1] = 8'h3C; add_exp[2] = 8'h78;
    add_exp[3] = 8'hF0; add_exp[4] = 8'hE0;
    add_flag_exp = 5'b10000;

    // Reset with step held, then keep step held after release.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("held_busy", int'(busy), 0);
    end
    check("held_count", int'(instr_count), 0);
    check("held_result", int'(result), 0);
    step = 1'b0;
    @(negedge clk);

    // LDI R1,5 with exact busy length.
    run_check("ldi_r1", 8'h15, 8'h05, 0);
    check("ldi_busy_len", busy_cycles, 3);
    check("ldi_count", int'(instr_count), 1);

    // LDI R0,15 then ADD R0,R0 five times.
    run_check("ldi_r0", 8'h0F, 8'h0F, 0);
    for (int i = 0; i < 5; i++)
      run_check($sformatf("add_%0d", i), 8'h40, int'(add_exp[i]), int'(add_flag_exp[i]));

    // SUB R2,R0 from R0=0x0F, then SHL R2 by 3.
    run_check("ldi_r0b", 8'h0F, 8'h0F, 0);
    run_check("sub_r2", 8'hA0, 8'hF1, 1);
    run_check("shl_r2", 8'hE3, 8'h88, 1);

    // Second edge and sw change while in flight are ignored.
    begin
      int c0;
      c0 = int'(instr_count);
      @(negedge clk); sw = 8'h39; step = 1'b1;
      @(negedge clk); step = 1'b0; sw = 8'h07;
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      repeat (6) @(negedge clk);
      check("ignore_count", int'(instr_count), (c0 + 1) % 256);
      check("ignore_result", int'(result), 8'h09);
    end

    // Reset asserted while in WRITE: half a cycle after edge k+2.
    @(negedge clk); sw = 8'h1C; step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    check("abort_count", int'(instr_count), 0);
    check("abort_result", int'(result), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_state", int'(state), int'(S_IDLE));

    // 256 LDIs into R2/R3 wrap the counter back to zero.
    for (int i = 0; i < 256; i++)
      run_instr({2'b00, 1'b1, 1'(i), 4'($urandom_range(0, 15))});
    check("wrap_count", int'(instr_count), 0);
    // R0 and R1 were cleared by the abort reset.
    run_check("cleared_regs", 8'h50, 0, 0);

    // Random stepping with random switch words.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      step = 1'($urandom_range(0, 1));
      sw   = 8'($urandom_range(0, 255));
    end
    step = 1'b0;
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    checks++;
    $display("FAIL global_timeout: simulation did not finish");
    $display("%0d/%0d checks passed", checks - fails, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/step_exec_ctrl.md
# step_exec_ctrl

Single-step instruction sequencer for the lab 4 switch/LED board. Each rising edge of the debounced step button latches the 8-bit switch word as an instruction. The block then sequences it through fetch, execute and write-back on a four-entry 8-bit register file, and presents the written value on the LEDs. It sits between the debouncer output and `led[7:0]` in the top level, replacing the direct switch-to-LED path.

## Interface
- `WIDTH`, 8: datapath and register width. The instruction encoding below holds only for 8.
- `CNT_W`, 8: width of the executed-instruction counter.

Ports:
- `clk`  in  1: system clock; all state on the rising edge.
- `rst`  in  1: asynchronous, active-high reset. Driven from the btnR path.
- `step`  in  1: debounced step level, synchronous to `clk`.
- `sw`  in  8: instruction word, sampled only on the start cycle.
- `result`  out  8: value written by the last completed instruction; drives `led`.
- `flag`  out  1: carry/borrow/shift-out of the last completed instruction.
- `busy`  out  1: high while an instruction is in flight.
- `instr_count`  out  CNT_W: number of completed instructions, modulo 2^CNT_W.

## Operation
- Instruction fields: opcode `sw[7:6]`, destination `d=sw[5:4]`, source `s=sw[3:2]`, `imm4=sw[3:0]`, `sh=sw[1:0]`.
- `00` LDI: `R[d] <= {4'b0, imm4}`. `flag <= 0`.
- `01` ADD: `R[d] <= R[d]+R[s]` (mod 256). `flag <= carry out`.
- `10` SUB: `R[d] <= R[d]-R[s]` (mod 256). `flag <= (R[d] < R[s])`, unsigned borrow.
- `11` SHL: `R[d] <= R[d] << sh`. `flag <=` OR of the bits shifted out. `flag = 0` when `sh = 0`.
- Start detection:
  - `step_q` is a registered copy of `step`.
  - `start = step & ~step_q & (state == IDLE)`.
- FSM states:
  - IDLE: on `start`, latch `sw` into `ir` and go to FETCH.
  - FETCH: read `R[d]` into `a` and `R[s]` into `b`, then go to EXEC.
  - EXEC: register the ALU result and next flag, then go to WRITE.
  - WRITE: write `R[d]`, update `result` and `flag`, increment `instr_count`, then go to IDLE.
- `d == s` is legal. Both operands read the same register (e.g. ADD R0,R0 doubles R0).
- Step edges arriving while `busy` is high are ignored, not queued. `step_q` still tracks `step`, so a press held past WRITE does not re-fire.
- `instr_count` wraps from 2^CNT_W−1 to 0.

## Timing
- Reset values:
  - All registers, `ir`, `a`, `b`, `result`, `flag` and `instr_count` are 0.
  - `busy` is 0 and state is IDLE.
  - `step_q` resets to 1, so a button held through reset release does not execute.
- Sequencing relative to the edge k at which `start` is true:
  - Edge k: enter FETCH. `busy` goes high after edge k.
  - Edge k+1: enter EXEC.
  - Edge k+2: enter WRITE.
  - Edge k+3: `result`, `flag`, `R[d]` and `instr_count` update, and the FSM returns to IDLE.
- `busy` is high for exactly 3 cycles.
- Throughput: at most one instruction per 4 cycles. In practice one per button press.
- `sw` changes after edge k have no effect on the instruction in flight.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-instruction, in any state, aborts it:
  - There is no partial write-back.
  - All state returns to reset values asynchronously.

## Structure
- Shared package `step_exec_pkg`:
  - Opcode constants OP_LDI, OP_ADD, OP_SUB, OP_SHL.
  - FSM state enum S_IDLE, S_FETCH, S_EXEC, S_WRITE.
  - Field-slice localparams.
- Sub-module `step_regfile`:
  - 4×WIDTH registers.
  - Two combinational read ports and one synchronous write port.
  - Asynchronous clear on `rst`.
- The ALU stays inline in the controller as a registered case on opcode in EXEC.

## Test plan
- Reset with `step=1`, then release reset holding `step=1` for 10 cycles → no execution. `instr_count=0`, `result=0`, `busy=0` throughout.
- `sw=0x15` (LDI R1,5), step edge → `busy` high for 3 cycles, then `result=0x05`, `flag=0`, `instr_count=1` at edge k+3.
- LDI R0,15 (`0x0F`), then ADD R0,R0 (`0x40`) ×5 → `result` sequence `0x1E, 0x3C, 0x78, 0xF0, 0xE0`. `flag` is 0,0,0,0,1.
- Starting from R0=0x0F, SUB R2,R0 (`0xA0`) → `result=0xF1`, `flag=1`. SHL R2 by 3 (`0xE3`) → `result=0x88`, `flag=1`.
- Second `step` rising edge during FETCH/EXEC, plus `sw` changed after edge k → ignored. Exactly one instruction completes, using the original `sw`.
- Reset pulse while in WRITE (edge k+2 + ½ cycle) → all registers read 0 afterwards, `instr_count=0`, FSM idle. 256 subsequent LDIs → `instr_count` wraps to 0.
